// File: rtl/dcim_pkg.sv
// Shared constants for the DCIM command front end: FSM state codes, opcodes,
// readback width and watchdog limit.
package dcim_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE     = 3'd0;
    localparam state_t W_DATA   = 3'd1;
    localparam state_t A_DATA   = 3'd2;
    localparam state_t RUN_WAIT = 3'd3;
    localparam state_t RD_LO    = 3'd4;
    localparam state_t RD_HI    = 3'd5;

    localparam logic [3:0] OP_WRITE_W  = 4'h1;
    localparam logic [3:0] OP_LOAD_ACT = 4'h2;
    localparam logic [3:0] OP_RUN      = 4'h3;
    localparam logic [3:0] OP_READ     = 4'h4;

    localparam int unsigned RD_W          = 16;
    localparam logic [7:0]  TIMEOUT_LIMIT = 8'd255;

endpackage

// File: rtl/dcim_cmd_rx.sv
// Byte-serial command parser feeding the DCIM array and returning its result.
// Define DCIM_CMD_TIMEOUT_EN to add an 8-bit RUN_WAIT watchdog.
module dcim_cmd_rx
    import dcim_pkg::*;
#(
    parameter int ROWS   = 16,
    parameter int RES_W  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              w_we,
    output logic [ADDR_W-1:0] w_addr,
    output logic [7:0]        w_data,
    output logic [7:0]        act,
    output logic              arr_start,
    input  logic              arr_done,
    input  logic [RES_W-1:0]  arr_result,
    output logic              busy,
    output logic              err
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [RD_W-1:0]   result_q, result_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              w_we_q, w_we_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [7:0]        w_data_q, w_data_d;
    logic [7:0]        act_q, act_d;
    logic              arr_start_q, arr_start_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              accept;
`ifdef DCIM_CMD_TIMEOUT_EN
    logic [7:0]        wd_q, wd_d;
`endif

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        result_d    = result_q;
        err_d       = err_q;
        act_d       = act_q;
        w_we_d      = 1'b0;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        arr_start_d = 1'b0;
`ifdef DCIM_CMD_TIMEOUT_EN
        wd_d        = '0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (in_data[7:4])
                        OP_WRITE_W: begin
                            row_d   = in_data[ADDR_W-1:0];
                            state_d = W_DATA;
                        end
                        OP_LOAD_ACT: state_d = A_DATA;
                        OP_RUN: begin
                            state_d     = RUN_WAIT;
                            arr_start_d = 1'b1;
                        end
                        OP_READ: state_d = RD_LO;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            W_DATA: begin
                if (accept) begin
                    if (int'(row_q) < ROWS) begin
                        w_we_d   = 1'b1;
                        w_addr_d = row_q;
                        w_data_d = in_data;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            A_DATA: begin
                if (accept) begin
                    act_d   = in_data;
                    state_d = IDLE;
                end
            end
            RUN_WAIT: begin
                // arr_done is ignored during the launch cycle itself
                if (!arr_start_q && arr_done) begin
                    result_d              = '0;
                    result_d[RES_W-1:0]   = arr_result;
                    state_d               = IDLE;
                end
`ifdef DCIM_CMD_TIMEOUT_EN
                else if (wd_q == TIMEOUT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
`endif
            end
            RD_LO: if (out_ready) state_d = RD_HI;
            RD_HI: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE) || (state_d == W_DATA) || (state_d == A_DATA);
        busy_d      = (state_d == RUN_WAIT) || (state_d == RD_LO) || (state_d == RD_HI);
        out_valid_d = (state_d == RD_LO) || (state_d == RD_HI);
        case (state_d)
            RD_LO:   out_data_d = result_q[7:0];
            RD_HI:   out_data_d = result_q[15:8];
            default: out_data_d = out_data_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            w_we_q      <= 1'b0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
            act_q       <= '0;
            arr_start_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            w_we_q      <= w_we_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            act_q       <= act_d;
            arr_start_q <= arr_start_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

`ifdef DCIM_CMD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`endif

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign w_we      = w_we_q;
    assign w_addr    = w_addr_q;
    assign w_data    = w_data_q;
    assign act       = act_q;
    assign arr_start = arr_start_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dcim_cmd_rx.sv
// Directed scoreboard bench for dcim_cmd_rx (ROWS=8, RES_W=16).
module tb_dcim_cmd_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        w_we;
    logic [3:0]  w_addr;
    logic [7:0]  w_data;
    logic [7:0]  act;
    logic        arr_start;
    logic        arr_done = 1'b0;
    logic [15:0] arr_result = '0;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    int we_pulses = 0;
    int start_pulses = 0;
    logic        model_en = 1'b1;
    logic [15:0] model_result = '0;

    logic [11:0] wq[$];
    logic [7:0]  rq[$];

    always #5 clk = ~clk;

    dcim_cmd_rx #(.ROWS(8), .RES_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .act(act),
        .arr_start(arr_start), .arr_done(arr_done), .arr_result(arr_result),
        .busy(busy), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output-side scoreboard: weight writes and readback bytes.
    always @(negedge clk) begin
        if (rst_n && w_we) begin
            we_pulses++;
            if (wq.size() == 0) chk("unexpected_w_we", {31'd0, w_we}, 32'd0);
            else begin
                logic [11:0] e;
                e = wq.pop_front();
                chk("w_addr", {28'd0, w_addr}, {28'd0, e[11:8]});
                chk("w_data", {24'd0, w_data}, {24'd0, e[7:0]});
            end
        end
        if (rst_n && arr_start) start_pulses++;
        if (rst_n && out_valid && out_ready) begin
            if (rq.size() == 0) chk("unexpected_out", {31'd0, out_valid}, 32'd0);
            else begin
                logic [7:0] e;
                e = rq.pop_front();
                chk("out_data", {24'd0, out_data}, {24'd0, e});
            end
        end
    end

    // Array model: answers each launch after 5 cycles with a one-cycle done.
    always @(negedge clk) begin
        if (rst_n && arr_start && model_en) begin
            repeat (5) @(negedge clk);
            if (model_en && rst_n) begin
                arr_result = model_result;
                arr_done   = 1'b1;
                @(negedge clk);
                arr_done   = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("send_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain_reads();
        int n;
        n = 0;
        while (rq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("read_drain", rq.size(), 32'd0);
        @(posedge clk);
        #1;
        chk("out_valid_after_read", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_data"},  {24'd0, out_data},  32'd0);
        chk({tag, "_w_we"},      {31'd0, w_we},      32'd0);
        chk({tag, "_w_addr"},    {28'd0, w_addr},    32'd0);
        chk({tag, "_w_data"},    {24'd0, w_data},    32'd0);
        chk({tag, "_act"},       {24'd0, act},       32'd0);
        chk({tag, "_arr_start"}, {31'd0, arr_start}, 32'd0);
        chk({tag, "_busy"},      {31'd0, busy},      32'd0);
        chk({tag, "_err"},       {31'd0, err},       32'd0);
    endtask

    initial begin
        int n;
        int p;
        // Reset state
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // WRITE_W row 3
        wq.push_back({4'd3, 8'hA5});
        send(8'h13);
        chk("in_ready_w_data", {31'd0, in_ready}, 32'd1);
        send(8'hA5);
        chk("w_we_latency", {31'd0, w_we}, 32'd1);
        repeat (3) @(negedge clk);
        chk("w_we_single", we_pulses, 32'd1);
        chk("write_err", {31'd0, err}, 32'd0);

        // READ before any RUN
        rq.push_back(8'h00); rq.push_back(8'h00);
        send(8'h40);
        chk("read_latency", {31'd0, out_valid}, 32'd1);
        drain_reads();

        // LOAD_ACT then RUN
        send(8'h20);
        send(8'h0F);
        chk("act", {24'd0, act}, 32'h0F);
        model_result = 16'h01C3;
        send(8'h30);
        chk("arr_start_latency", {31'd0, arr_start}, 32'd1);
        chk("busy_run", {31'd0, busy}, 32'd1);
        chk("in_ready_run", {31'd0, in_ready}, 32'd0);
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        chk("run_done", {31'd0, busy}, 32'd0);
        chk("arr_start_once", start_pulses, 32'd1);

        // READ with backpressure
        out_ready = 1'b0;
        rq.push_back(8'hC3); rq.push_back(8'h01);
        send(8'h40);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_data", {24'd0, out_data}, 32'hC3);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain_reads();

        // Stray arr_done in IDLE, then repeated READ
        @(negedge clk);
        arr_result = 16'hBEEF; arr_done = 1'b1;
        @(negedge clk);
        arr_done = 1'b0;
        rq.push_back(8'hC3); rq.push_back(8'h01);
        send(8'h40);
        drain_reads();

        // Out-of-range row and illegal opcode
        p = we_pulses;
        send(8'h1C);
        send(8'hFF);
        repeat (2) @(negedge clk);
        chk("bad_row_no_we", we_pulses, p);
        chk("bad_row_err", {31'd0, err}, 32'd1);
        send(8'h77);
        @(negedge clk);
        chk("illegal_err", {31'd0, err}, 32'd1);
        chk("illegal_idle_ready", {31'd0, in_ready}, 32'd1);
        chk("illegal_idle_busy", {31'd0, busy}, 32'd0);

        // Reset while in RUN_WAIT
        model_en = 1'b0;
        send(8'h30);
        repeat (3) @(negedge clk);
        chk("midrun_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        rq.push_back(8'h00); rq.push_back(8'h00);
        send(8'h40);
        drain_reads();

`ifdef DCIM_CMD_TIMEOUT_EN
        // Watchdog expiry, then a late arr_done must not update the result
        send(8'h30);
        n = 0;
        while (busy && n < 400) begin @(negedge clk); n++; end
        chk("timeout_idle", {31'd0, busy}, 32'd0);
        chk("timeout_window", {31'd0, (n >= 250 && n <= 260)}, 32'd1);
        chk("timeout_err", {31'd0, err}, 32'd1);
        @(negedge clk);
        arr_result = 16'h5555; arr_done = 1'b1;
        @(negedge clk);
        arr_done = 1'b0;
        rq.push_back(8'h00); rq.push_back(8'h00);
        send(8'h40);
        drain_reads();
`endif

        repeat (2) @(negedge clk);
        chk("wq_empty", wq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
